// File: rtl/fp32_pkg.sv
// Shared definitions for the fp32 multiply sequencer: field widths, special
// encodings, the sequencer state type and operand classification.
package fp32_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_WAIT_LO = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_NORM    = 3'd4,
    ST_ROUND   = 3'd5,
    ST_PACK    = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  // Packed so the struct reads as {is_nan, is_inf, is_zero}.
  typedef struct packed {
    logic is_nan;
    logic is_inf;
    logic is_zero;
  } cls_t;

  // Denormals count as zero because they are flushed.
  function automatic cls_t classify(input logic [31:0] x);
    cls_t c;
    c.is_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
    c.is_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
    c.is_zero = (x[30:23] == 8'h00);
    return c;
  endfunction

endpackage

// File: rtl/fp32_round_pack.sv
// Combinational normalize / round / overflow-underflow / pack helpers for
// the fp32 multiply sequencer. Each output group feeds a different FSM state.
// FP32_MUL_RNE_EN: round-to-nearest-even on the guard bit; otherwise truncate.
module fp32_round_pack #(
  parameter int BIAS = fp32_pkg::BIAS
) (
  input  logic              sign_i,
  input  logic [7:0]        ea_i,
  input  logic [7:0]        eb_i,
  input  logic [24:0]       prod_i,
  input  logic signed [9:0] e_i,
  input  logic [22:0]       m_i,
  input  logic              g_i,
  output logic signed [9:0] norm_e_o,
  output logic [22:0]       norm_m_o,
  output logic              norm_g_o,
  output logic signed [9:0] rnd_e_o,
  output logic [22:0]       rnd_m_o,
  output logic [31:0]       pack_o
);
  import fp32_pkg::*;

  localparam logic signed [9:0] BIAS_E = 10'(BIAS);
  localparam logic signed [9:0] EXP_LIM = 10'(EXP_MAX);

  logic signed [9:0] e_sum_s;

  // Normalize: a product in [2,4) shifts right one place and bumps the exponent.
  always_comb begin
    e_sum_s = $signed({2'b00, ea_i}) + $signed({2'b00, eb_i}) - BIAS_E;
    if (prod_i[24]) begin
      norm_m_o = prod_i[23:1];
      norm_g_o = prod_i[0];
      norm_e_o = e_sum_s + 10'sd1;
    end else begin
      norm_m_o = prod_i[22:0];
      norm_g_o = 1'b0;
      norm_e_o = e_sum_s;
    end
  end

`ifdef FP32_MUL_RNE_EN
  // Round: no sticky bit exists, so a set guard is a tie and rounds to even.
  always_comb begin
    rnd_m_o = m_i;
    rnd_e_o = e_i;
    if (g_i && m_i[0]) begin
      if (m_i == 23'h7F_FFFF) begin
        rnd_m_o = 23'h0;
        rnd_e_o = e_i + 10'sd1;
      end else begin
        rnd_m_o = m_i + 23'd1;
        rnd_e_o = e_i;
      end
    end else begin
      rnd_m_o = m_i;
      rnd_e_o = e_i;
    end
  end
`else
  logic unused_g_s;
  assign unused_g_s = g_i;

  // Round: truncation, the mantissa and exponent pass straight through.
  always_comb begin
    rnd_m_o = m_i;
    rnd_e_o = e_i;
  end
`endif

  // Pack: saturate to infinity on overflow, flush to zero on underflow.
  always_comb begin
    if (e_i >= EXP_LIM) begin
      pack_o = {sign_i, POS_INF[30:0]};
    end else if (e_i <= 10'sd0) begin
      pack_o = {sign_i, 31'h0};
    end else begin
      pack_o = {sign_i, e_i[7:0], m_i};
    end
  end

endmodule

// File: rtl/fp32_mul_seq.sv
// fp32 multiply sequencer: classifies operands, drives the external mantissa
// multiplier through its start/done handshake and packs the final result.
// FP32_MUL_RNE_EN (optional): enables round-to-nearest-even in fp32_round_pack.
module fp32_mul_seq #(
  parameter int BIAS = fp32_pkg::BIAS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [22:0] mul_a,
  output logic [22:0] mul_b,
  output logic        mul_start,
  input  logic        mul_done,
  input  logic [24:0] mul_res
);
  import fp32_pkg::*;

  state_t            state_q, state_d;
  cls_t              cls_a_s, cls_b_s;
  logic              sign_s, special_s;
  logic [31:0]       special_res_s;

  logic              sign_q, special_q;
  logic [31:0]       special_res_q;
  logic [7:0]        ea_q, eb_q;
  logic [24:0]       prod_q;
  logic signed [9:0] e_q;
  logic [22:0]       m_q;
  logic              g_q;
  logic [31:0]       result_q;
  logic              busy_q, done_q, mul_start_q;
  logic [22:0]       mul_a_q, mul_b_q;

  logic signed [9:0] norm_e_s, rnd_e_s;
  logic [22:0]       norm_m_s, rnd_m_s;
  logic              norm_g_s;
  logic [31:0]       pack_s;

  // Classify the incoming operands; specials bypass the multiplier entirely.
  always_comb begin
    cls_a_s       = classify(op_a);
    cls_b_s       = classify(op_b);
    sign_s        = op_a[31] ^ op_b[31];
    special_s     = 1'b0;
    special_res_s = 32'h0;
    if (cls_a_s.is_nan || cls_b_s.is_nan ||
        (cls_a_s.is_inf && cls_b_s.is_zero) || (cls_a_s.is_zero && cls_b_s.is_inf)) begin
      special_s     = 1'b1;
      special_res_s = QNAN;
    end else if (cls_a_s.is_inf || cls_b_s.is_inf) begin
      special_s     = 1'b1;
      special_res_s = {sign_s, POS_INF[30:0]};
    end else if (cls_a_s.is_zero || cls_b_s.is_zero) begin
      special_s     = 1'b1;
      special_res_s = {sign_s, 31'h0};
    end else begin
      special_s     = 1'b0;
      special_res_s = 32'h0;
    end
  end

  // Next-state logic; WAIT_LO/WAIT_HI demand a full low-then-high done sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    begin
        if (start) state_d = special_s ? ST_PACK : ST_LAUNCH;
        else       state_d = ST_IDLE;
      end
      ST_LAUNCH:  state_d = ST_WAIT_LO;
      ST_WAIT_LO: begin
        if (!mul_done) state_d = ST_WAIT_HI;
        else           state_d = ST_WAIT_LO;
      end
      ST_WAIT_HI: begin
        if (mul_done) state_d = ST_NORM;
        else          state_d = ST_WAIT_HI;
      end
      ST_NORM:    state_d = ST_ROUND;
      ST_ROUND:   state_d = ST_PACK;
      ST_PACK:    state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Datapath and registered outputs, each stage loaded in its own state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q        <= 1'b0;
      special_q     <= 1'b0;
      special_res_q <= 32'h0;
      ea_q          <= 8'h0;
      eb_q          <= 8'h0;
      prod_q        <= 25'h0;
      e_q           <= 10'sd0;
      m_q           <= 23'h0;
      g_q           <= 1'b0;
      result_q      <= 32'h0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mul_start_q   <= 1'b0;
      mul_a_q       <= 23'h0;
      mul_b_q       <= 23'h0;
    end else begin
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
      mul_start_q <= (state_d == ST_LAUNCH);
      if ((state_q == ST_IDLE) && start) begin
        sign_q        <= sign_s;
        special_q     <= special_s;
        special_res_q <= special_res_s;
        ea_q          <= op_a[30:23];
        eb_q          <= op_b[30:23];
        if (!special_s) begin
          mul_a_q <= op_a[22:0];
          mul_b_q <= op_b[22:0];
        end
      end
      if ((state_q == ST_WAIT_HI) && mul_done) prod_q <= mul_res;
      if (state_q == ST_NORM) begin
        e_q <= norm_e_s;
        m_q <= norm_m_s;
        g_q <= norm_g_s;
      end
      if (state_q == ST_ROUND) begin
        e_q <= rnd_e_s;
        m_q <= rnd_m_s;
      end
      if (state_q == ST_PACK) result_q <= special_q ? special_res_q : pack_s;
    end
  end

  fp32_round_pack #(.BIAS(BIAS)) u_round_pack (
    .sign_i   (sign_q),
    .ea_i     (ea_q),
    .eb_i     (eb_q),
    .prod_i   (prod_q),
    .e_i      (e_q),
    .m_i      (m_q),
    .g_i      (g_q),
    .norm_e_o (norm_e_s),
    .norm_m_o (norm_m_s),
    .norm_g_o (norm_g_s),
    .rnd_e_o  (rnd_e_s),
    .rnd_m_o  (rnd_m_s),
    .pack_o   (pack_s)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_fp32_mul_seq.sv
// Scoreboard bench for fp32_mul_seq with a behavioural 26-cycle mantissa
// multiplier and an arithmetic reference model of fp32 multiplication.
module tb_fp32_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] op_a = 32'h0;
  logic [31:0] op_b = 32'h0;
  logic        busy, done, mul_start, mul_done;
  logic [31:0] result;
  logic [22:0] mul_a, mul_b;
  logic [24:0] mul_res;

  int          total = 0;
  int          bad = 0;
  int          mstart_cnt = 0;
  logic        prev_mstart = 1'b0;
  logic [31:0] sb_q[$];
  logic [31:0] expv;

  fp32_mul_seq dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
    .mul_done(mul_done), .mul_res(mul_res)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural mantissa multiplier ----------------
  int          mcnt;
  logic        mdone_r;
  logic [24:0] mres_r;
  logic [22:0] cap_a, cap_b;

  function automatic logic [24:0] prod25(input logic [22:0] a, input logic [22:0] b);
    logic [47:0] p;
    p = 48'({1'b1, a}) * 48'({1'b1, b});
    return p[47:23];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdone_r <= 1'b1; mcnt <= 0; mres_r <= 25'h0; cap_a <= 23'h0; cap_b <= 23'h0;
    end else if (mul_start && mdone_r) begin
      mdone_r <= 1'b0; mcnt <= 25; cap_a <= mul_a; cap_b <= mul_b;
      mres_r  <= prod25(mul_a, mul_b);
    end else if (!mdone_r) begin
      if (mcnt == 0) mdone_r <= 1'b1;
      else           mcnt <= mcnt - 1;
    end
  end

  assign mul_done = mdone_r;
  assign mul_res  = mres_r;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic s; int ea, eb, e; logic [47:0] p; logic [23:0] m; logic g; logic [31:0] ev;
    logic a_nan, b_nan;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    a_nan = (ea == 255) && (a[22:0] != 23'h0);
    b_nan = (eb == 255) && (b[22:0] != 23'h0);
    if (a_nan || b_nan || (ea == 255 && eb == 0) || (eb == 255 && ea == 0)) return 32'h7FC0_0000;
    if (ea == 255 || eb == 255) return {s, 8'hFF, 23'h0};
    if (ea == 0 || eb == 0) return {s, 31'h0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = ea + eb - 127;
    if (p[47]) begin m = {1'b0, p[46:24]}; g = p[23]; e = e + 1; end
    else       begin m = {1'b0, p[45:23]}; g = 1'b0; end
`ifdef FP32_MUL_RNE_EN
    if (g && m[0]) m = m + 24'd1;
    if (m[23]) begin m = 24'd0; e = e + 1; end
`else
    if (g) m = m;
`endif
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    ev = e;
    return {s, ev[7:0], m[22:0]};
  endfunction

  function automatic bit is_spec(input logic [31:0] a, input logic [31:0] b);
    return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) || (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] e; logic [22:0] f; int sel;
    sel = $urandom_range(0, 9);
    f   = 23'($urandom);
    case (sel)
      0: e = 8'h00;
      1: begin e = 8'hFF; if ($urandom_range(0, 1) == 1) f = 23'h0; end
      2, 3: e = 8'($urandom_range(1, 254));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, f};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (mul_start) begin
        mstart_cnt++;
        chk("mul_start_pulse_prev", 32'(prev_mstart), 32'h0);
      end
      prev_mstart = mul_start;
      if (!mdone_r && mcnt == 0) begin
        chk("mul_a_stable", 32'(mul_a), 32'(cap_a));
        chk("mul_b_stable", 32'(mul_b), 32'(cap_b));
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL done_unexpected: done with result 0x%08h, required no done", result);
        end else begin
          expv = sb_q.pop_front();
          chk("result", result, expv);
        end
      end
    end else begin
      prev_mstart = 1'b0;
    end
  end

  // ---------------- driver ----------------
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ev,
                        input bit poke_busy, input bit poke_done);
    int lat; bit seen; bit spec; int want_lat;
    spec     = is_spec(a, b);
    want_lat = spec ? 2 : 32;
    @(negedge clk);
    sb_q.push_back(ev);
    mstart_cnt = 0;
    start = 1'b1; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0; op_a = $urandom; op_b = $urandom;
    lat = 1; seen = 1'b0;
    while (!seen && lat < 300) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        start = poke_busy && (lat == 5);
        @(negedge clk);
        lat++;
      end
    end
    start = 1'b0;
    if (!seen) begin
      total++; bad++;
      $display("FAIL done_timeout: no done after %0d cycles, required %0d", lat, want_lat);
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      sb_q.delete();
      return;
    end
    chk("latency", 32'(lat), 32'(want_lat));
    chk("mul_start_count", 32'(mstart_cnt), spec ? 32'd0 : 32'd1);
    if (poke_done) begin start = 1'b1; op_a = 32'h3F80_0000; op_b = 32'h3F80_0000; end
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_done", 32'(busy), 32'h0);
  endtask

  initial begin
    // reset values
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_mul_start", 32'(mul_start), 32'h0);
    chk("rst_mul_a", 32'(mul_a), 32'h0);
    chk("rst_mul_b", 32'(mul_b), 32'h0);
    rst = 1'b0;

    // directed cases with hand-derived expectations
    run_op(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b0, 1'b1);
    run_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b1, 1'b0);
    run_op(32'h0000_0000, 32'h3F80_0000, 32'h0000_0000, 1'b0, 1'b1);
    run_op(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b0, 1'b0);
    run_op(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1'b0);
    run_op(32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 1'b0, 1'b0);
    run_op(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1'b0);
    run_op(32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b0, 1'b0);
    run_op(32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 1'b0, 1'b0);

    // reset while waiting on the multiplier
    @(negedge clk);
    start = 1'b1; op_a = 32'h3FC0_0000; op_b = 32'h3FC0_0000;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    chk("midrst_result", result, 32'h0);
    chk("midrst_mul_a", 32'(mul_a), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b0, 1'b0);

    // randomized operands against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      ra = rand_fp();
      rb = rand_fp();
      run_op(ra, rb, ref_mul(ra, rb), (i % 7) == 3, (i % 5) == 1);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
